// File: rtl/piradip_cdc_update_sink.sv
// Destination-domain sink for the auto-updating CDC word path: holds the latest
// word as a level and queues every update into a small AXI-Stream FIFO with loss accounting.
module piradip_cdc_update_sink #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               COALESCE  = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_update,
    output logic [WIDTH-1:0]         current,
    output logic [WIDTH-1:0]         m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    input  logic                     clear_overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] newest_ptr;
    logic [LVL_W-1:0] level_q, level_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] current_q, current_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_q, drop_d;

    logic pop, full, store, loss, coalesce_wr;

    always_comb begin
        pop         = valid_q & m_tready;
        full        = (level_q == FULL_LVL);
        // A pop frees the slot in the same edge, so a full queue still accepts.
        store       = in_update & (~full | pop);
        loss        = in_update & full & ~pop;
        coalesce_wr = loss & COALESCE;
        newest_ptr  = wr_ptr_q - PTR_W'(1);

        wr_ptr_d = store ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        case ({store, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        valid_d = (level_d != '0);

        current_d = in_update ? in_data : current_q;

        // A loss coinciding with a clear is the first loss of the new epoch.
        if (clear_overflow) begin
            overflow_d = loss;
            drop_d     = {15'd0, loss};
        end else begin
            overflow_d = overflow_q | loss;
            drop_d     = (loss && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[wr_ptr_q] <= in_data;
        end else if (coalesce_wr) begin
            mem_q[newest_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            valid_q    <= 1'b0;
            current_q  <= RESET_VAL;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            current_q  <= current_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign current    = current_q;
    assign m_tdata    = mem_q[rd_ptr_q];
    assign m_tvalid   = valid_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule
